// File: rtl/acc_sequencer.sv
// acc_sequencer: runs a fixed-length accumulation of unsigned samples.
// A run is started with start/num_samples, clears the accumulator for one
// cycle, then adds num_samples accepted samples and pulses done.
//
// Handshake: a sample transfers on a rising edge where in_valid=1 and
// in_ready=1. in_ready depends only on the FSM state (high in ACCUM), never on
// in_valid. A producer may hold in_valid low to stall. An abort in the same
// cycle wins, and that sample is not added.
module acc_sequencer #(
    parameter int WORD_LENGTH = 8,
    parameter int SUM_LENGTH  = 16,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] num_samples,
    input  logic                   in_valid,
    input  logic [WORD_LENGTH-1:0] in_data,
    output logic                   in_ready,
    output logic [SUM_LENGTH-1:0]  sum_out,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // state_q is kept as a named enum so checkers can bind to it directly.
    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [SUM_LENGTH-1:0]  sum_q, sum_d;
    logic                   ovf_q, ovf_d;
    logic [SUM_LENGTH:0]    add_w;

    // One extra bit captures the carry out of the wrapping add.
    assign add_w = {1'b0, sum_q} + {{(SUM_LENGTH + 1 - WORD_LENGTH){1'b0}}, in_data};

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state and datapath update for the run sequence.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                // A zero-length run is meaningless and is ignored.
                if (start && (num_samples != '0)) begin
                    state_d     = S_CLEAR;
                    remaining_d = num_samples;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    sum_d       = add_w[SUM_LENGTH-1:0];
                    ovf_d       = ovf_q | add_w[SUM_LENGTH];
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decode the state alone so reset forces them low at once.
    assign in_ready = (state_q == S_ACCUM);
    assign busy     = (state_q == S_CLEAR) || (state_q == S_ACCUM);
    assign done     = (state_q == S_DONE);
    assign sum_out  = sum_q;
    assign overflow = ovf_q;

endmodule
